// File: rtl/spi_master_sequencer_if.sv
// Host and SPI-master facing signal bundle for the SPI master sequencer.
// The sequencer connects through the slave modport. The host side and the
// SPI master side connect through the master modport.
`timescale 1ns/1ps
interface spi_master_sequencer_if #(
  parameter int bits_size = 8,
  parameter int addr_w    = 3
);
  // Host TX side
  logic                 wr_en;
  logic [bits_size-1:0] wr_data;
  logic                 tx_full;
  logic [addr_w:0]      tx_count;
  // Host RX side
  logic                 rd_en;
  logic [bits_size-1:0] rd_data;
  logic                 rx_empty;
  logic [addr_w:0]      rx_count;
  logic                 rx_overflow;
  logic                 busy;
  // SPI master side
  logic [bits_size-1:0] spi_data_in;
  logic                 spi_tx_start;
  logic                 spi_rx_done;
  logic [bits_size-1:0] spi_data_out;

  modport slave (
    input  wr_en, wr_data, rd_en, spi_rx_done, spi_data_out,
    output tx_full, tx_count, rd_data, rx_empty, rx_count, rx_overflow, busy,
           spi_data_in, spi_tx_start
  );

  modport master (
    output wr_en, wr_data, rd_en, spi_rx_done, spi_data_out,
    input  tx_full, tx_count, rd_data, rx_empty, rx_count, rx_overflow, busy,
           spi_data_in, spi_tx_start
  );
endinterface

// File: rtl/spi_master_sequencer.sv
// SPI master sequencer: queues host bytes in a TX FIFO, runs one full-duplex
// SPI frame per byte back-to-back, and stores each received byte in an RX
// FIFO that the host drains (first-word-fall-through read port).
`timescale 1ns/1ps
module spi_master_sequencer #(
  parameter int bits_size  = 8,
  parameter int fifo_depth = 8,
  parameter int addr_w     = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  spi_master_sequencer_if.slave   bus
);

  // Frame sequencing states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_STORE = 3'd4;

  localparam logic [addr_w:0]   depth_c   = (addr_w + 1)'(fifo_depth);
  localparam logic [addr_w:0]   zero_c    = {(addr_w + 1){1'b0}};
  localparam logic [addr_w:0]   one_c     = (addr_w + 1)'(32'd1);
  localparam logic [addr_w-1:0] ptr_one_c = (addr_w)'(32'd1);
  localparam logic [addr_w-1:0] ptr_zero_c = {addr_w{1'b0}};
  localparam logic [bits_size-1:0] byte_zero_c = {bits_size{1'b0}};

  // TX FIFO state
  logic [bits_size-1:0] tx_mem_r [fifo_depth];
  logic [addr_w-1:0]    tx_wr_ptr_r;
  logic [addr_w-1:0]    tx_rd_ptr_r;
  logic [addr_w:0]      tx_count_r;
  logic                 tx_full_r;
  logic [addr_w:0]      tx_count_nxt_s;

  // RX FIFO state
  logic [bits_size-1:0] rx_mem_r [fifo_depth];
  logic [addr_w-1:0]    rx_wr_ptr_r;
  logic [addr_w-1:0]    rx_rd_ptr_r;
  logic [addr_w:0]      rx_count_r;
  logic                 rx_empty_r;
  logic                 rx_overflow_r;
  logic [addr_w:0]      rx_count_nxt_s;

  // Sequencer state
  logic [2:0]           state_r;
  logic [2:0]           state_nxt_s;
  logic [bits_size-1:0] spi_data_in_r;
  logic                 spi_tx_start_r;
  logic                 busy_r;
  logic [bits_size-1:0] rx_capture_r;

  // FIFO handshake qualifiers
  logic tx_push_s;
  logic tx_pop_s;
  logic rx_push_s;
  logic rx_pop_s;
  logic rx_drop_s;

  // Qualify host requests against the start-of-cycle FIFO flags and decide
  // whether the captured byte can be stored (a same-cycle host pop frees room).
  always_comb begin
    tx_push_s = bus.wr_en & ~tx_full_r;
    tx_pop_s  = (state_r == ST_IDLE) && (tx_count_r != zero_c);
    rx_pop_s  = bus.rd_en & ~rx_empty_r;
    if (state_r == ST_STORE) begin
      rx_push_s = (rx_count_r != depth_c) || rx_pop_s;
    end else begin
      rx_push_s = 1'b0;
    end
    rx_drop_s = (state_r == ST_STORE) && !rx_push_s;
  end

  // Next TX occupancy from the push/pop pair.
  always_comb begin
    tx_count_nxt_s = tx_count_r;
    case ({tx_push_s, tx_pop_s})
      2'b10:   tx_count_nxt_s = tx_count_r + one_c;
      2'b01:   tx_count_nxt_s = tx_count_r - one_c;
      default: tx_count_nxt_s = tx_count_r;
    endcase
  end

  // Next RX occupancy from the push/pop pair.
  always_comb begin
    rx_count_nxt_s = rx_count_r;
    case ({rx_push_s, rx_pop_s})
      2'b10:   rx_count_nxt_s = rx_count_r + one_c;
      2'b01:   rx_count_nxt_s = rx_count_r - one_c;
      default: rx_count_nxt_s = rx_count_r;
    endcase
  end

  // Frame sequencing: one LOAD cycle settles data before the start pulse,
  // and WAIT holds with no timeout until the master reports completion.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (tx_count_r != zero_c) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD:  state_nxt_s = ST_START;
      ST_START: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (bus.spi_rx_done) begin
          state_nxt_s = ST_STORE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_STORE: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // TX FIFO storage, pointers and registered occupancy flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < fifo_depth; i++) begin
        tx_mem_r[i] <= byte_zero_c;
      end
      tx_wr_ptr_r <= ptr_zero_c;
      tx_rd_ptr_r <= ptr_zero_c;
      tx_count_r  <= zero_c;
      tx_full_r   <= 1'b0;
    end else begin
      if (tx_push_s) begin
        tx_mem_r[tx_wr_ptr_r] <= bus.wr_data;
        tx_wr_ptr_r           <= tx_wr_ptr_r + ptr_one_c;
      end
      if (tx_pop_s) begin
        tx_rd_ptr_r <= tx_rd_ptr_r + ptr_one_c;
      end
      tx_count_r <= tx_count_nxt_s;
      tx_full_r  <= (tx_count_nxt_s == depth_c);
    end
  end

  // RX FIFO storage, pointers, registered occupancy flags and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < fifo_depth; i++) begin
        rx_mem_r[i] <= byte_zero_c;
      end
      rx_wr_ptr_r   <= ptr_zero_c;
      rx_rd_ptr_r   <= ptr_zero_c;
      rx_count_r    <= zero_c;
      rx_empty_r    <= 1'b1;
      rx_overflow_r <= 1'b0;
    end else begin
      if (rx_push_s) begin
        rx_mem_r[rx_wr_ptr_r] <= rx_capture_r;
        rx_wr_ptr_r           <= rx_wr_ptr_r + ptr_one_c;
      end
      if (rx_pop_s) begin
        rx_rd_ptr_r <= rx_rd_ptr_r + ptr_one_c;
      end
      rx_count_r <= rx_count_nxt_s;
      rx_empty_r <= (rx_count_nxt_s == zero_c);
      if (rx_drop_s) begin
        rx_overflow_r <= 1'b1;
      end
    end
  end

  // Sequencer registers: state, held TX byte, start pulse, busy and RX capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_IDLE;
      spi_data_in_r  <= byte_zero_c;
      spi_tx_start_r <= 1'b0;
      busy_r         <= 1'b0;
      rx_capture_r   <= byte_zero_c;
    end else begin
      state_r        <= state_nxt_s;
      spi_tx_start_r <= (state_nxt_s == ST_START);
      busy_r         <= (state_nxt_s != ST_IDLE);
      if (tx_pop_s) begin
        spi_data_in_r <= tx_mem_r[tx_rd_ptr_r];
      end
      if ((state_r == ST_WAIT) && bus.spi_rx_done) begin
        rx_capture_r <= bus.spi_data_out;
      end
    end
  end

  assign bus.tx_full      = tx_full_r;
  assign bus.tx_count     = tx_count_r;
  assign bus.rd_data      = rx_mem_r[rx_rd_ptr_r];
  assign bus.rx_empty     = rx_empty_r;
  assign bus.rx_count     = rx_count_r;
  assign bus.rx_overflow  = rx_overflow_r;
  assign bus.busy         = busy_r;
  assign bus.spi_data_in  = spi_data_in_r;
  assign bus.spi_tx_start = spi_tx_start_r;

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Directed-plus-random bench for spi_master_sequencer with a behavioural SPI
// master responder and queue-based expectations.
`timescale 1ns/1ps
module tb_spi_master_sequencer;
  localparam int bits_size  = 8;
  localparam int fifo_depth = 8;
  localparam int addr_w     = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_sequencer_if #(.bits_size(bits_size), .addr_w(addr_w)) bus ();

  spi_master_sequencer #(
    .bits_size (bits_size),
    .fifo_depth(fifo_depth),
    .addr_w    (addr_w)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  // SPI master responder state
  logic       rsp_done = 1'b0;
  logic       spur_done = 1'b0;
  logic [7:0] rsp_data = 8'h00;
  logic [7:0] rsp_cur = 8'h00;
  int         rsp_cnt = 0;
  int         rsp_len = 0;
  bit         hold = 1'b0;
  int         fixed_len = 0;
  int         stab_err = 0;
  int         overlap_err = 0;
  int         flag_err = 0;
  int         start_cyc_q[$];
  int         len_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] exp_tx_q[$];
  int         push_cyc = 0;

  assign bus.spi_rx_done  = rsp_done | spur_done;
  assign bus.spi_data_out = rsp_data;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] resp(input logic [7:0] b);
    return b ^ 8'h99;
  endfunction

  // Behavioural SPI master: latch byte on tx_start, finish rsp_len cycles later.
  initial begin
    forever begin
      @(negedge clk);
      rsp_done = 1'b0;
      if (!reset_n) begin
        rsp_cnt = 0;
      end else if (bus.spi_tx_start) begin
        if (rsp_cnt != 0) overlap_err++;
        rsp_cur = bus.spi_data_in;
        sent_q.push_back(rsp_cur);
        start_cyc_q.push_back(cyc);
        rsp_len = (fixed_len > 0) ? fixed_len : int'($urandom_range(10, 2));
        len_q.push_back(rsp_len);
        rsp_cnt = rsp_len;
      end else if (rsp_cnt != 0) begin
        if (bus.spi_data_in !== rsp_cur) stab_err++;
        if (!hold) begin
          rsp_cnt--;
          if (rsp_cnt == 0) begin
            rsp_done = 1'b1;
            rsp_data = resp(rsp_cur);
          end
        end
      end
    end
  end

  // Flag consistency: full only at 8 entries, empty only at 0.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.tx_full !== (bus.tx_count == 4'd8)) flag_err++;
      if (bus.rx_empty !== (bus.rx_count == 4'd0)) flag_err++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    push_cyc    = cyc;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, {24'd0, bus.rd_data}, {24'd0, exp});
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (bus.tx_count == 4'd0 && !bus.busy && rsp_cnt == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic clear_log();
    sent_q.delete();
    start_cyc_q.delete();
    len_q.delete();
    exp_tx_q.delete();
  endtask

  task automatic chk_sent(input string tag);
    chk({tag, "_frames"}, sent_q.size(), exp_tx_q.size());
    for (int i = 0; i < exp_tx_q.size() && i < sent_q.size(); i++)
      chk({tag, "_byte"}, {24'd0, sent_q[i]}, {24'd0, exp_tx_q[i]});
  endtask

  initial begin
    logic [7:0] b;
    bit got;
    int lat;
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.rd_en = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tx_count", {28'd0, bus.tx_count}, 32'd0);
    chk("rst_tx_full", {31'd0, bus.tx_full}, 32'd0);
    chk("rst_rx_empty", {31'd0, bus.rx_empty}, 32'd1);
    chk("rst_rx_count", {28'd0, bus.rx_count}, 32'd0);
    chk("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
    chk("rst_spi_data_in", {24'd0, bus.spi_data_in}, 32'd0);
    chk("rst_tx_start", {31'd0, bus.spi_tx_start}, 32'd0);
    chk("rst_overflow", {31'd0, bus.rx_overflow}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single frame 0xA5 -> 0x3C
    clear_log();
    fixed_len = 5;
    push(8'hA5);
    exp_tx_q.push_back(8'hA5);
    chk("t1_idle_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    chk("t1_load_data", {24'd0, bus.spi_data_in}, 32'hA5);
    chk("t1_load_busy", {31'd0, bus.busy}, 32'd1);
    chk("t1_load_nostart", {31'd0, bus.spi_tx_start}, 32'd0);
    @(negedge clk);
    chk("t1_start", {31'd0, bus.spi_tx_start}, 32'd1);
    chk("t1_start_data", {24'd0, bus.spi_data_in}, 32'hA5);
    @(negedge clk);
    chk("t1_start_end", {31'd0, bus.spi_tx_start}, 32'd0);
    chk("t1_wait_data", {24'd0, bus.spi_data_in}, 32'hA5);
    wait_drain("t1_drain");
    lat = (start_cyc_q.size() > 0) ? start_cyc_q[0] - push_cyc : -1;
    chk("t1_start_latency", lat, 32'd3);
    chk_sent("t1");
    chk("t1_rx_count", {28'd0, bus.rx_count}, 32'd1);
    chk("t1_busy_end", {31'd0, bus.busy}, 32'd0);
    pop_chk("t1_rd_data", 8'h3C);
    chk("t1_rx_empty", {31'd0, bus.rx_empty}, 32'd1);

    // Spurious rx_done while idle is ignored
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    chk("spur_rx_count", {28'd0, bus.rx_count}, 32'd0);
    chk("spur_busy", {31'd0, bus.busy}, 32'd0);

    // Eight back-to-back frames 0x01..0x08, random frame lengths
    clear_log();
    fixed_len = 0;
    for (int i = 1; i <= 8; i++) begin
      push(8'(i));
      exp_tx_q.push_back(8'(i));
    end
    wait_drain("t2_drain");
    chk_sent("t2");
    for (int i = 1; i < start_cyc_q.size(); i++)
      chk("t2_gap", start_cyc_q[i] - start_cyc_q[i-1], len_q[i-1] + 4);
    chk("t2_rx_count", {28'd0, bus.rx_count}, 32'd8);
    chk("t2_overflow", {31'd0, bus.rx_overflow}, 32'd0);
    for (int i = 0; i < 8; i++) pop_chk("t2_rx", resp(exp_tx_q[i]));
    chk("t2_rx_empty", {31'd0, bus.rx_empty}, 32'd1);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk("t2_pop_empty", {28'd0, bus.rx_count}, 32'd0);

    // Fill TX while a frame is held, push 0xFF when full, then run 9 frames without popping
    clear_log();
    hold = 1'b1;
    b = 8'($urandom_range(254, 0));
    push(b);
    exp_tx_q.push_back(b);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(254, 0));
      push(b);
      exp_tx_q.push_back(b);
    end
    chk("t3_tx_count_full", {28'd0, bus.tx_count}, 32'd8);
    chk("t3_tx_full", {31'd0, bus.tx_full}, 32'd1);
    push(8'hFF);
    chk("t3_push_ignored", {28'd0, bus.tx_count}, 32'd8);
    hold = 1'b0;
    wait_drain("t3_drain");
    chk_sent("t3");
    chk("t4_rx_count", {28'd0, bus.rx_count}, 32'd8);
    chk("t4_overflow", {31'd0, bus.rx_overflow}, 32'd1);
    for (int i = 0; i < 8; i++) pop_chk("t4_rx", resp(exp_tx_q[i]));
    chk("t4_overflow_sticky", {31'd0, bus.rx_overflow}, 32'd1);

    // Reset in WAIT with 3 bytes queued
    clear_log();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push(8'($urandom_range(255, 0)));
    chk("t5_queued", {28'd0, bus.tx_count}, 32'd3);
    chk("t5_busy", {31'd0, bus.busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_tx_count", {28'd0, bus.tx_count}, 32'd0);
    chk("t5_rx_empty", {31'd0, bus.rx_empty}, 32'd1);
    chk("t5_tx_start", {31'd0, bus.spi_tx_start}, 32'd0);
    chk("t5_busy_rst", {31'd0, bus.busy}, 32'd0);
    chk("t5_overflow", {31'd0, bus.rx_overflow}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    hold = 1'b0;
    reset_n = 1'b1;
    clear_log();
    repeat (20) @(negedge clk);
    chk("t5_no_frame", start_cyc_q.size(), 32'd0);
    chk("t5_idle", {31'd0, bus.busy}, 32'd0);

    // RX full, host pops during the STORE cycle of the 9th frame
    clear_log();
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom_range(255, 0));
      push(b);
      exp_tx_q.push_back(b);
    end
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      #1;
      got = (sent_q.size() == 9);
    end
    chk("t6_ninth_start", {31'd0, got}, 32'd1);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      #1;
      got = bus.spi_rx_done;
    end
    chk("t6_ninth_done", {31'd0, got}, 32'd1);
    @(negedge clk);
    chk("t6_store_full", {28'd0, bus.rx_count}, 32'd8);
    pop_chk("t6_store_pop", resp(exp_tx_q[0]));
    chk("t6_rx_count", {28'd0, bus.rx_count}, 32'd8);
    chk("t6_overflow", {31'd0, bus.rx_overflow}, 32'd0);
    wait_drain("t6_drain");
    chk_sent("t6");
    for (int i = 1; i < 9; i++) pop_chk("t6_rx", resp(exp_tx_q[i]));
    chk("t6_rx_empty", {31'd0, bus.rx_empty}, 32'd1);

    // Whole-run monitors
    chk("data_stable", stab_err, 32'd0);
    chk("start_overlap", overlap_err, 32'd0);
    chk("flag_consistency", flag_err, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_master_sequencer.md
Name: spi_master_sequencer

Overview:
Host-side buffering stage directly upstream of the SPI master. It queues host bytes in a TX FIFO and presents them one at a time to the master's data_in/tx_start. It waits for each transfer to complete, then stores the byte shifted in from MISO into an RX FIFO that the host drains. One full-duplex SPI frame is run per queued byte, back-to-back, with no host intervention.

Parameters:
bits_size, 8, SPI frame width; must match the SPI master's bits_size.
fifo_depth, 8, entries per FIFO; power of two, at least 2.
addr_w, 3, log2(fifo_depth).

Ports:
clk  input  1  system clock, same clock as the SPI master
reset_n  input  1  asynchronous active-low reset
wr_en  input  1  host push into TX FIFO
wr_data  input  bits_size  byte to transmit
tx_full  output  1  TX FIFO full
tx_count  output  addr_w+1  TX FIFO occupancy
rd_en  input  1  host pop from RX FIFO
rd_data  output  bits_size  RX FIFO head (first-word-fall-through)
rx_empty  output  1  RX FIFO empty
rx_count  output  addr_w+1  RX FIFO occupancy
rx_overflow  output  1  sticky: a received byte was dropped
busy  output  1  FSM not in IDLE
spi_data_in  output  bits_size  to SPI master data_in
spi_tx_start  output  1  to SPI master tx_start
spi_rx_done  input  1  from SPI master rx_done (1-cycle pulse)
spi_data_out  input  bits_size  from SPI master data_out

Behaviour:
- Reset (async, reset_n=0):
  - Both FIFOs are emptied: pointers=0, counts=0, tx_full=0, rx_empty=1.
  - rd_data=0, spi_data_in=0, spi_tx_start=0, rx_overflow=0, busy=0, FSM=IDLE.
- TX FIFO:
  - wr_en while tx_full=1 is ignored; contents are unchanged.
  - Simultaneous push and pop while full: the pop frees a slot, but the push is still ignored because tx_full is evaluated at the cycle start.
  - Pointers wrap modulo fifo_depth. Count is addr_w+1 bits so that 0..fifo_depth is represented exactly.
- RX FIFO:
  - rd_data shows the head entry combinationally from storage; rd_en pops it.
  - rd_en while rx_empty=1 is ignored.
  - Push and pop in the same cycle, when not empty, leave the count unchanged.
- FSM states: IDLE, LOAD, START, WAIT, STORE.
  - IDLE: if tx_count!=0, pop the TX head into spi_data_in and go to LOAD.
  - LOAD: one cycle so data is stable before start; go to START.
  - START: spi_tx_start=1 for exactly one cycle; go to WAIT.
  - WAIT: spi_data_in is held stable. On spi_rx_done=1, capture spi_data_out and go to STORE.
  - STORE: if rx_count<fifo_depth, push the captured byte; otherwise drop it and set rx_overflow. Go to IDLE.
- Back-to-back frames: from IDLE to the next START is 2 cycles, so the minimum inter-frame gap is STORE+IDLE+LOAD = 3 clk.
- A host pop in the STORE cycle frees space for that same push; rx_count is evaluated including the pop.
- spi_rx_done outside WAIT is ignored.
- No timeout: WAIT holds indefinitely until spi_rx_done.
- busy=1 in every state except IDLE.
- rx_overflow is cleared only by reset.
- Reset mid-frame returns everything to the reset state immediately. The SPI master shares reset_n, so no partial frame survives.

Test Plan:
- Reset, then push 0xA5. Expect: spi_tx_start pulses once 2 cycles after the push is seen in IDLE; spi_data_in=0xA5 from LOAD through WAIT. Drive spi_rx_done with spi_data_out=0x3C. Expect rx_count=1, rd_data=0x3C, busy returns to 0.
- Push 8 bytes 0x01..0x08 with the master loopback model. Expect exactly 8 tx_start pulses, each separated by at least the frame length plus 3 clk. Expect the RX FIFO to read back the slave pattern in order, and tx_full=1 only while 8 entries are queued.
- Fill TX (tx_full=1), then push 0xFF. Expect count to stay 8 and 0xFF never to appear on spi_data_in.
- Never pop RX and run 9 frames. Expect rx_count=8, rx_overflow=1, and the first 8 received bytes intact.
- Assert reset_n=0 in WAIT with 3 bytes queued. Expect immediately: tx_count=0, rx_empty=1, spi_tx_start=0, busy=0. After release, no frame starts until a new push.
- With the RX FIFO full, pop in the STORE cycle. Expect the byte to be stored, rx_count to stay 8, and rx_overflow to stay 0.
